// File: rtl/softmax_out_writer.sv
// Packs four lane results per word and writes them to output memory at addresses 0..lim.
// Latency: word accepted at edge K appears on wr_en/wr_addr/wr_data at cycle K+1 if the output stage is free.
// Backpressure: a 2-entry FIFO absorbs wr_ready stalls; in_ready (registered-only) drops when the FIFO is full.
module softmax_out_writer #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRSIZE-1:0]      addr_limit,
  input  logic                     in_valid,
  input  logic [DATAWIDTH-1:0]     outp0,
  input  logic [DATAWIDTH-1:0]     outp1,
  input  logic [DATAWIDTH-1:0]     outp2,
  input  logic [DATAWIDTH-1:0]     outp3,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRSIZE-1:0]      wr_addr,
  output logic [DATAWIDTH*NUM-1:0] wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [ADDRSIZE-1:0]      lim_q;
  logic [ADDRSIZE-1:0]      acc_q;
  logic [ADDRSIZE-1:0]      addr_q;
  logic                     wr_en_q;
  logic [DATAWIDTH*NUM-1:0] data_q;
  logic                     ovf_q;
  logic                     done_q;
  logic [DATAWIDTH*NUM-1:0] fifo_q [2];
  logic                     rd_q;
  logic                     wp_q;
  logic [1:0]               cnt_q;

  logic                     push, pop_wr, stage_free, fifo_pop, fifo_push, bypass;
  logic                     last_acc, last_wr, start_go;
  logic [DATAWIDTH*NUM-1:0] in_word;

  // Handshake and buffer-steering decode shared by FSM and datapath
  always_comb begin
    in_word    = {outp3, outp2, outp1, outp0};
    push       = in_valid && in_ready;
    pop_wr     = wr_en_q && wr_ready;
    stage_free = !wr_en_q || pop_wr;
    fifo_pop   = stage_free && (cnt_q != 2'd0);
    bypass     = stage_free && (cnt_q == 2'd0) && push;
    fifo_push  = push && !bypass;
    last_acc   = push && (acc_q == lim_q);
    last_wr    = pop_wr && (addr_q == lim_q);
    start_go   = (state_q == IDLE) && start;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: arm on start, drain after the last word is taken, idle after the last write lands
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_acc) state_d = FLUSH;
      FLUSH:   if (last_wr)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs: depend only on registers, so no input-to-ready combinational path
  always_comb begin
    in_ready = (state_q == RUN) && (cnt_q < 2'd2);
    busy     = (state_q != IDLE);
  end

  // Datapath: counters, 2-entry FIFO, registered write stage, status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lim_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_q      <= 1'b0;
      wp_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (start_go) begin
      lim_q   <= addr_limit;
      acc_q   <= '0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wp_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      done_q <= (state_q == FLUSH) && last_wr;
      // Words offered outside RUN have nowhere to go
      if (in_valid && (state_q != RUN)) ovf_q <= 1'b1;
      if (push && (acc_q != lim_q))     acc_q <= acc_q + 1'b1;
      // Address saturates at lim so it never wraps
      if (pop_wr && (addr_q != lim_q))  addr_q <= addr_q + 1'b1;
      if (stage_free) begin
        wr_en_q <= fifo_pop || bypass;
        if (fifo_pop)    data_q <= fifo_q[rd_q];
        else if (bypass) data_q <= in_word;
      end
      if (fifo_push) begin
        fifo_q[wp_q] <= in_word;
        wp_q         <= ~wp_q;
      end
      if (fifo_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: doc/softmax_out_writer.md
# softmax_out_writer

Result write-back engine for the softmax datapath. It accepts the four per-lane outputs (`outp0`..`outp3`) that `softmax` produces each result cycle and packs them into one `DATAWIDTH*NUM`-bit word. It writes the words to the output memory at consecutive addresses starting at 0, mirroring the packed layout the input memories use for reads. It owns the address counter, a 2-entry buffer that absorbs memory back-pressure, and the end-of-vector handshake.

## Interface
- `DATAWIDTH`, 16, width of one lane value (fp16)
- `NUM`, 4, lanes per word
- `ADDRSIZE`, 8, memory address width
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0); one clock domain
- `start`  in  1  one-cycle pulse that arms a new vector write
- `addr_limit`  in  ADDRSIZE  last address to write; sampled on `start`
- `in_valid`  in  1  `outp0..3` hold a valid result word
- `outp0`..`outp3`  in  DATAWIDTH each  lane results; `outp0` maps to word bits [DATAWIDTH-1:0], `outp3` to the MSBs
- `in_ready`  out  1  word accepted on a cycle where `in_valid && in_ready`
- `wr_en`  out  1  memory write request
- `wr_addr`  out  ADDRSIZE  write address
- `wr_data`  out  DATAWIDTH*NUM  packed word {outp3,outp2,outp1,outp0}
- `wr_ready`  in  1  memory accepts the write on a cycle where `wr_en && wr_ready`
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  one-cycle pulse after the final write is accepted
- `overflow`  out  1  sticky error flag; cleared by `start`

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on `start`. Latches `addr_limit` into `lim`. Clears `acc_cnt`, `wr_addr`, the buffer, and `overflow`.
  - RUN -> FLUSH when word number `lim` is accepted, i.e. the (`lim`+1)-th word.
  - FLUSH -> IDLE when the last write (`wr_addr == lim`) is accepted. `done` pulses in the next cycle.
- Word count is `lim+1`, inclusive of `lim`. If `addr_limit = 0`, exactly one word is written.
- `in_ready = (state==RUN) && (buffered < 2)`. It depends only on registers: no combinational path from `in_valid` or `wr_ready`.
- Buffer: 2-entry FIFO feeding a registered output stage (`wr_en`/`wr_addr`/`wr_data`).
  - The output stage loads the FIFO head, or the incoming word if the FIFO is empty, whenever the stage is empty or its write is accepted this cycle.
- `wr_addr` increments by 1 after each accepted write. It never wraps: it stops at `lim` (max 2^ADDRSIZE-1).
- While `wr_en` is high and `wr_ready` is low, `wr_addr` and `wr_data` are held stable.
- `in_valid` while in IDLE or FLUSH: the word is dropped and `overflow` is set. It stays set until the next `start`.
- `start` while in RUN or FLUSH: ignored. No change to `lim`, counters, or `overflow`.
- Push and pop in the same cycle: both take effect and the occupancy is unchanged.
- `reset` asserted mid-vector: immediately returns to IDLE and discards buffered words. No further `wr_en` is issued.

## Timing
- Reset values: `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`, `overflow=0`.
- `start` at edge N: `busy=1` and `in_ready=1` from cycle N+1.
- Latency: a word accepted at edge K with the output stage free gives `wr_en=1` at cycle K+1 with its address and data.
- Throughput: 1 word/cycle when `wr_ready` is held high.
- `done` is high for exactly one cycle, the cycle after the final write handshake. `busy` falls in that same cycle.

## Test plan
- `addr_limit=2`, `start`, 3 words back-to-back with `wr_ready=1`. Words are 0x993e_4210_4040_3800, then +1, then +2.
  - Required: writes at addr 0,1,2 on consecutive cycles, each one cycle after its acceptance.
  - Required: `done` pulses once, then `busy=0` and `in_ready=0`.
- `addr_limit=3`, `wr_ready` low for 4 cycles after the first write request.
  - Required: `in_ready` drops after 2 more words are buffered.
  - Required: `wr_addr=0` and `wr_data` are held stable while stalled.
  - Required: all 4 words are written in order with no loss or duplication.
- `addr_limit=0`, one word 0x0000_0000_0000_3c00.
  - Required: a single write to addr 0 with data 0x0000_0000_0000_3c00.
  - Required: `done` pulses 2 cycles after acceptance.
- `in_valid=1` while in IDLE.
  - Required: no `wr_en`, and `overflow=1`.
  - Required: the next `start` clears `overflow` to 0.
- `start` pulsed again during RUN with a different `addr_limit`.
  - Required: it is ignored; the original limit governs the word count.
- `reset` driven low after 1 of 3 writes.
  - Required: all outputs are 0 within the reset, and no `wr_en` follows until a new `start`.
